rst_seq_ctrl: RTL and testbench

Reset sequencer that generates the active-low, asynchronously asserted reset lines consumed by the library's async-reset flops. It asserts all outputs immediately on the external `rst_n` and releases them synchronously to `clk`. Outputs are released in a fixed order with a programmable stretch and inter-domain gap. A synchronous software reset request and acknowledge handshake re-runs the same sequence without an external reset.

---
 rtl/rst_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all rst_out_n asynchronously on rst_n and releases
// them in order, synchronously to clk, with a stretch and per-output gap.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int STRETCH     = 16,
  parameter int GAP         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               busy,
  output logic               all_rel
);

  localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NUM_OUT-1:0]     rst_out_n_q, rst_out_n_d;
  logic                   busy_q, busy_d;
  logic                   all_rel_q, all_rel_d;
  logic                   ack_q, ack_d;
  logic                   sw_flag_q, sw_flag_d;
  logic [NUM_OUT-1:0]     rel_vec;
  logic                   final_rel;
  logic                   rel_now;

  // Output vector after one more release: bit i follows bit i-1, bit 0 goes first.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rel
      if (gi == 0) begin : g_first
        assign rel_vec[gi] = 1'b1;
      end else begin : g_next
        assign rel_vec[gi] = rst_out_n_q[gi-1];
      end
    end
  endgenerate

  assign final_rel = &rel_vec;
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    rst_out_n_d = rst_out_n_q;
    busy_d      = busy_q;
    all_rel_d   = all_rel_q;
    ack_d       = ack_q;
    sw_flag_d   = sw_flag_q;
    rel_now     = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        cnt_d = '0;
        // Leave on the edge that fills the last synchronizer stage, so the
        // stretch count starts at edge SYNC_STAGES.
        if (sync_q[SYNC_STAGES-2]) begin
          state_d = ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          rel_now = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          rel_now = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (ack_q && !sw_rst_req) begin
          ack_d = 1'b0;
        end
        if (sw_rst_req && !ack_q) begin
          rst_out_n_d = '0;
          busy_d      = 1'b1;
          all_rel_d   = 1'b0;
          sw_flag_d   = 1'b1;
          state_d     = ST_STRETCH;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    if (rel_now) begin
      cnt_d       = '0;
      rst_out_n_d = rel_vec;
      state_d     = ST_RELEASE;
      if (final_rel) begin
        state_d   = ST_RUN;
        busy_d    = 1'b0;
        all_rel_d = 1'b1;
        ack_d     = sw_flag_q & sw_rst_req;
        sw_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      sync_q      <= '0;
      rst_out_n_q <= '0;
      busy_q      <= 1'b1;
      all_rel_q   <= 1'b0;
      ack_q       <= 1'b0;
      sw_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      rst_out_n_q <= rst_out_n_d;
      busy_q      <= busy_d;
      all_rel_q   <= all_rel_d;
      ack_q       <= ack_d;
      sw_flag_q   <= sw_flag_d;
    end
  end

  assign rst_out_n  = rst_out_n_q;
  assign busy       = busy_q;
  assign all_rel    = all_rel_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: expected output-change events are queued with the
// edge they must occur on, then popped as the DUT outputs change.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [3:0] rst_out_n;
  logic       busy;
  logic       all_rel;

  logic       sw_rst_req2;
  logic       sw_rst_ack2;
  logic [0:0] rst_out_n2;
  logic       busy2;
  logic       all_rel2;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_cnt;
  logic [6:0]  prev_obs;
  logic [38:0] sb_q[$];
  int          rise_cnt[4] = '{default: 0};
  logic [3:0]  glitch_prev = 4'b0000;

  rst_seq_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .rst_out_n  (rst_out_n),
    .busy       (busy),
    .all_rel    (all_rel)
  );

  rst_seq_ctrl #(
    .SYNC_STAGES (3),
    .NUM_OUT     (1),
    .STRETCH     (1),
    .GAP         (1)
  ) u_corner (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req2),
    .sw_rst_ack (sw_rst_ack2),
    .rst_out_n  (rst_out_n2),
    .busy       (busy2),
    .all_rel    (all_rel2)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first rising clk with rst_n high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Counts every rising transition of each output, including sub-cycle ones.
  always @(rst_out_n) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_out_n[i] === 1'b1 && glitch_prev[i] !== 1'b1) rise_cnt[i]++;
    end
    glitch_prev = rst_out_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [38:0] mk(input int e, input logic [3:0] ro,
                                     input logic b, input logic ar, input logic ak);
    return {e[31:0], ro, b, ar, ak};
  endfunction

  // Waits (bounded) for the next change of {rst_out_n, busy, all_rel, ack}.
  task automatic wait_change(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ({rst_out_n, busy, all_rel, sw_rst_ack} !== prev_obs) begin
        prev_obs  = {rst_out_n, busy, all_rel, sw_rst_ack};
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    sw_rst_req  = 1'b0;
    sw_rst_req2 = 1'b0;
    repeat (3) @(negedge clk);
    prev_obs = 7'b0000_1_0_0;
  endtask

  task automatic push_por();
    sb_q.push_back(mk(18, 4'b0001, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(26, 4'b0011, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(34, 4'b0111, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(42, 4'b1111, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rst_out_n !== 4'b0000) begin
      n_bad++; $display("FAIL reset_rst_out_n: got %b, expected 0000", rst_out_n);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy: got %b, expected 1", busy);
    end
    n_cmp++;
    if (all_rel !== 1'b0) begin
      n_bad++; $display("FAIL reset_all_rel: got %b, expected 0", all_rel);
    end
    n_cmp++;
    if (sw_rst_ack !== 1'b0) begin
      n_bad++; $display("FAIL reset_ack: got %b, expected 0", sw_rst_ack);
    end
    n_cmp++;
    if (rst_out_n2 !== 1'b0) begin
      n_bad++; $display("FAIL reset_corner_out: got %b, expected 0", rst_out_n2);
    end
  endtask

  task automatic test_por();
    logic [38:0] exp_v;
    bit          to;
    int          base[4];
    apply_reset();
    base = rise_cnt;
    push_por();
    rst_n = 1'b1;
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      wait_change(300, to);
      n_cmp++;
      if (to || {edge_cnt, prev_obs} !== exp_v) begin
        n_bad++;
        $display("FAIL por_event: got edge %0d out/busy/all_rel/ack %b (timeout %0d), expected edge %0d %b",
                 edge_cnt, prev_obs, to, exp_v[38:7], exp_v[6:0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rise_cnt[i] - base[i] !== 1) begin
        n_bad++;
        $display("FAIL por_glitch: bit %0d rose %0d times, expected 1", i, rise_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_sw_reset();
    logic [38:0] exp_v;
    bit          to;
    int          e;
    int          base[4];
    base = rise_cnt;
    sw_rst_req = 1'b1;
    e = edge_cnt + 1;
    sb_q.push_back(mk(e,      4'b0000, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 16, 4'b0001, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 24, 4'b0011, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 32, 4'b0111, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 40, 4'b1111, 1'b0, 1'b1, 1'b1));
    for (int ph = 0; ph < 2; ph++) begin
      while (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        wait_change(300, to);
        n_cmp++;
        if (to || {edge_cnt, prev_obs} !== exp_v) begin
          n_bad++;
          $display("FAIL sw_event: got edge %0d out/busy/all_rel/ack %b (timeout %0d), expected edge %0d %b",
                   edge_cnt, prev_obs, to, exp_v[38:7], exp_v[6:0]);
        end
      end
      if (ph == 0) begin
        sw_rst_req = 1'b0;
        sb_q.push_back(mk(e + 41, 4'b1111, 1'b0, 1'b1, 1'b0));
      end
    end
    wait_change(30, to);
    n_cmp++;
    if (!to) begin
      n_bad++;
      $display("FAIL sw_quiet: got change at edge %0d to %b, expected no change", edge_cnt, prev_obs);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rise_cnt[i] - base[i] !== 1) begin
        n_bad++;
        $display("FAIL sw_glitch: bit %0d rose %0d times, expected 1", i, rise_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_early_drop();
    logic [38:0] exp_v;
    bit          to;
    int          e;
    sw_rst_req = 1'b1;
    e = edge_cnt + 1;
    sb_q.push_back(mk(e,      4'b0000, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 16, 4'b0001, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 24, 4'b0011, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 32, 4'b0111, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(e + 40, 4'b1111, 1'b0, 1'b1, 1'b0));
    fork
      begin
        repeat (5) @(negedge clk);
        sw_rst_req = 1'b0;
      end
    join_none
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      wait_change(300, to);
      n_cmp++;
      if (to || {edge_cnt, prev_obs} !== exp_v) begin
        n_bad++;
        $display("FAIL early_drop_event: got edge %0d out/busy/all_rel/ack %b (timeout %0d), expected edge %0d %b",
                 edge_cnt, prev_obs, to, exp_v[38:7], exp_v[6:0]);
      end
    end
    wait_change(20, to);
    n_cmp++;
    if (!to) begin
      n_bad++;
      $display("FAIL early_drop_quiet: got change at edge %0d to %b, expected no change", edge_cnt, prev_obs);
    end
  endtask

  task automatic test_ignored_req();
    logic [38:0] exp_v;
    bit          to;
    apply_reset();
    push_por();
    sb_q.push_back(mk(43, 4'b0000, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(59, 4'b0001, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(67, 4'b0011, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(75, 4'b0111, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(83, 4'b1111, 1'b0, 1'b1, 1'b1));
    sb_q.push_back(mk(84, 4'b1111, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;
    fork
      begin
        repeat (19) @(negedge clk);
        sw_rst_req = 1'b1;
        repeat (64) @(negedge clk);
        sw_rst_req = 1'b0;
      end
    join_none
    while (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      wait_change(300, to);
      n_cmp++;
      if (to || {edge_cnt, prev_obs} !== exp_v) begin
        n_bad++;
        $display("FAIL ignored_req_event: got edge %0d out/busy/all_rel/ack %b (timeout %0d), expected edge %0d %b",
                 edge_cnt, prev_obs, to, exp_v[38:7], exp_v[6:0]);
      end
    end
  endtask

  task automatic test_async_abort();
    logic [38:0] exp_v;
    bit          to;
    int          e;
    int          abort_at;
    int          base[4];
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        apply_reset();
        sb_q.push_back(mk(18, 4'b0001, 1'b1, 1'b0, 1'b0));
        sb_q.push_back(mk(26, 4'b0011, 1'b1, 1'b0, 1'b0));
        rst_n    = 1'b1;
        abort_at = 30;
      end else begin
        sw_rst_req = 1'b1;
        e = edge_cnt + 1;
        sb_q.push_back(mk(e,      4'b0000, 1'b1, 1'b0, 1'b0));
        sb_q.push_back(mk(e + 16, 4'b0001, 1'b1, 1'b0, 1'b0));
        abort_at = e + 20;
      end
      while (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        wait_change(300, to);
        n_cmp++;
        if (to || {edge_cnt, prev_obs} !== exp_v) begin
          n_bad++;
          $display("FAIL abort_pre_event: phase %0d got edge %0d obs %b (timeout %0d), expected edge %0d %b",
                   ph, edge_cnt, prev_obs, to, exp_v[38:7], exp_v[6:0]);
        end
      end
      while (edge_cnt < abort_at) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rst_out_n, busy, all_rel, sw_rst_ack} !== 7'b0000_1_0_0) begin
        n_bad++;
        $display("FAIL abort_async: phase %0d got out/busy/all_rel/ack %b, expected 0000100",
                 ph, {rst_out_n, busy, all_rel, sw_rst_ack});
      end
      sw_rst_req = 1'b0;
      #2 rst_n = 1'b1;
      prev_obs = 7'b0000_1_0_0;
      base = rise_cnt;
      push_por();
      while (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        wait_change(300, to);
        n_cmp++;
        if (to || {edge_cnt, prev_obs} !== exp_v) begin
          n_bad++;
          $display("FAIL abort_restart_event: phase %0d got edge %0d obs %b (timeout %0d), expected edge %0d %b",
                   ph, edge_cnt, prev_obs, to, exp_v[38:7], exp_v[6:0]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rise_cnt[i] - base[i] !== 1) begin
          n_bad++;
          $display("FAIL abort_glitch: phase %0d bit %0d rose %0d times, expected 1",
                   ph, i, rise_cnt[i] - base[i]);
        end
      end
    end
  endtask

  task automatic test_corner();
    logic [35:0] exp_c;
    bit          found;
    int          e;
    apply_reset();
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rst_out_n2 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    exp_c = {32'd4, 4'b1010};
    n_cmp++;
    if (!found || {edge_cnt, rst_out_n2, busy2, all_rel2, sw_rst_ack2} !== exp_c) begin
      n_bad++;
      $display("FAIL corner_por: got edge %0d out/busy/all_rel/ack %b (found %0d), expected edge 4 1010",
               edge_cnt, {rst_out_n2, busy2, all_rel2, sw_rst_ack2}, found);
    end
    sw_rst_req2 = 1'b1;
    e = edge_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      case (k)
        0:       exp_c = {e,     4'b0100};
        1:       exp_c = {e + 1, 4'b1011};
        default: exp_c = {e + 2, 4'b1010};
      endcase
      n_cmp++;
      if ({edge_cnt, rst_out_n2, busy2, all_rel2, sw_rst_ack2} !== exp_c) begin
        n_bad++;
        $display("FAIL corner_sw: step %0d got edge %0d out/busy/all_rel/ack %b, expected edge %0d %b",
                 k, edge_cnt, {rst_out_n2, busy2, all_rel2, sw_rst_ack2}, exp_c[35:4], exp_c[3:0]);
      end
      if (k == 1) sw_rst_req2 = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    sw_rst_req  = 1'b0;
    sw_rst_req2 = 1'b0;
    prev_obs    = 7'b0000_1_0_0;
    test_reset();
    test_por();
    test_sw_reset();
    test_early_drop();
    test_ignored_req();
    test_async_abort();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
